// File: rtl/req_gnt_liveness_mon.sv
`default_nettype none
// ============================================================================
// Module      : req_gnt_liveness_mon
// Description : Multi-channel request/grant liveness monitor with a bounded
//               grant window, pass/timeout pulses, sticky errors, saturating
//               counters and per-channel latency tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module req_gnt_liveness_mon #(
    parameter int NUM_CH   = 4,
    parameter int MAX_WAIT = 8,
    parameter int LAT_W    = 4,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        en,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        gnt,
    input  logic                     clr,
    output logic [NUM_CH-1:0]        pass_pulse,
    output logic [NUM_CH-1:0]        timeout_pulse,
    output logic [NUM_CH-1:0]        err_sticky,
    output logic [NUM_CH-1:0]        busy,
    output logic [NUM_CH*LAT_W-1:0]  last_lat,
    output logic [NUM_CH*LAT_W-1:0]  max_lat,
    output logic [CNT_W-1:0]         pass_cnt,
    output logic [CNT_W-1:0]         fail_cnt
);

    localparam logic [1:0] C_ST_IDLE    = 2'd0;
    localparam logic [1:0] C_ST_WAIT    = 2'd1;
    localparam logic [1:0] C_ST_TIMEOUT = 2'd2;

    localparam int PC_W  = $clog2(NUM_CH + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

    localparam logic [LAT_W-1:0] C_MAX_WAIT = LAT_W'(MAX_WAIT);
    localparam logic [LAT_W-1:0] C_LAT_ONE  = LAT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};

    logic [NUM_CH-1:0][1:0]       r_state,    w_state_nxt;
    logic [NUM_CH-1:0][LAT_W-1:0] r_cnt,      w_cnt_nxt;
    logic [NUM_CH-1:0][LAT_W-1:0] r_last_lat, w_last_lat_nxt;
    logic [NUM_CH-1:0][LAT_W-1:0] r_max_lat,  w_max_lat_nxt;
    logic [NUM_CH-1:0]            r_pass,     w_pass;
    logic [NUM_CH-1:0]            r_to,       w_to;
    logic [NUM_CH-1:0]            r_err,      w_err_nxt;
    logic [NUM_CH-1:0]            r_busy,     w_busy_nxt;
    logic [CNT_W-1:0]             r_pass_cnt, w_pass_cnt_nxt;
    logic [CNT_W-1:0]             r_fail_cnt, w_fail_cnt_nxt;

    logic [PC_W-1:0]              w_pass_pop, w_to_pop;
    logic [SUM_W-1:0]             w_pass_sum, w_fail_sum;
    logic [LAT_W-1:0]             w_max_base;

    // Per-channel window FSM; disable overrides every other transition.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            w_pass[i]      = 1'b0;
            w_to[i]        = 1'b0;
            if (!en[i]) begin
                w_state_nxt[i] = C_ST_IDLE;
                w_cnt_nxt[i]   = '0;
            end else begin
                case (r_state[i])
                    C_ST_IDLE: begin
                        if (req[i]) begin
                            w_state_nxt[i] = C_ST_WAIT;
                            w_cnt_nxt[i]   = C_LAT_ONE;
                        end
                    end
                    C_ST_WAIT: begin
                        if (gnt[i]) begin
                            w_pass[i] = 1'b1;
                            if (req[i]) begin
                                w_cnt_nxt[i] = C_LAT_ONE;
                            end else begin
                                w_state_nxt[i] = C_ST_IDLE;
                                w_cnt_nxt[i]   = '0;
                            end
                        end else if (r_cnt[i] == C_MAX_WAIT) begin
                            w_to[i]        = 1'b1;
                            w_state_nxt[i] = C_ST_TIMEOUT;
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] + C_LAT_ONE;
                        end
                    end
                    C_ST_TIMEOUT: begin
                        if (gnt[i]) begin
                            if (req[i]) begin
                                w_state_nxt[i] = C_ST_WAIT;
                                w_cnt_nxt[i]   = C_LAT_ONE;
                            end else begin
                                w_state_nxt[i] = C_ST_IDLE;
                                w_cnt_nxt[i]   = '0;
                            end
                        end
                    end
                    default: begin
                        w_state_nxt[i] = C_ST_IDLE;
                        w_cnt_nxt[i]   = '0;
                    end
                endcase
            end
            w_busy_nxt[i] = (w_state_nxt[i] != C_ST_IDLE);
        end
    end

    // Same-cycle events take priority over clr.
    always_comb begin
        w_pass_pop = '0;
        w_to_pop   = '0;
        w_max_base = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_pass_pop = w_pass_pop + PC_W'(w_pass[i]);
            w_to_pop   = w_to_pop   + PC_W'(w_to[i]);
            w_err_nxt[i]      = w_to[i] | (r_err[i] & ~clr);
            w_last_lat_nxt[i] = w_pass[i] ? r_cnt[i] : r_last_lat[i];
            w_max_base        = clr ? '0 : r_max_lat[i];
            w_max_lat_nxt[i]  = (w_pass[i] && (r_cnt[i] > w_max_base)) ? r_cnt[i] : w_max_base;
        end
        w_pass_sum = SUM_W'(clr ? '0 : r_pass_cnt) + SUM_W'(w_pass_pop);
        w_fail_sum = SUM_W'(clr ? '0 : r_fail_cnt) + SUM_W'(w_to_pop);
        w_pass_cnt_nxt = (w_pass_sum > SUM_W'(C_CNT_MAX)) ? C_CNT_MAX : w_pass_sum[CNT_W-1:0];
        w_fail_cnt_nxt = (w_fail_sum > SUM_W'(C_CNT_MAX)) ? C_CNT_MAX : w_fail_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= '0;
            r_cnt      <= '0;
            r_last_lat <= '0;
            r_max_lat  <= '0;
            r_pass     <= '0;
            r_to       <= '0;
            r_err      <= '0;
            r_busy     <= '0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_last_lat <= w_last_lat_nxt;
            r_max_lat  <= w_max_lat_nxt;
            r_pass     <= w_pass;
            r_to       <= w_to;
            r_err      <= w_err_nxt;
            r_busy     <= w_busy_nxt;
            r_pass_cnt <= w_pass_cnt_nxt;
            r_fail_cnt <= w_fail_cnt_nxt;
        end
    end

    assign pass_pulse    = r_pass;
    assign timeout_pulse = r_to;
    assign err_sticky    = r_err;
    assign busy          = r_busy;
    assign last_lat      = r_last_lat;
    assign max_lat       = r_max_lat;
    assign pass_cnt      = r_pass_cnt;
    assign fail_cnt      = r_fail_cnt;

endmodule
`default_nettype wire
